// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter: round-robin owner of the single PmodOLEDrgb SPI byte transmitter.
// Ports: req/byte_* per requester in, tx_* to the transmitter, grant/burst_active/timeout_* status out.
// Latency: grant one edge after req; byte path req->tx is combinational; watchdog revokes stalled bursts.
module oled_spi_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         byte_valid,
  input  logic [8*N_REQ-1:0]       byte_data,
  input  logic [N_REQ-1:0]         byte_dc,
  input  logic [N_REQ-1:0]         byte_last,
  output logic [N_REQ-1:0]         byte_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_dc,
  input  logic                     tx_ready,
  output logic                     burst_active,
  output logic [N_REQ-1:0]         grant,
  output logic                     timeout_err,
  output logic [$clog2(N_REQ)-1:0] timeout_id
);

  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    gidx_q, gidx_d;     // index of the owner, kept beside the one-hot grant
  logic [PW-1:0]    ptr_q, ptr_d;       // last owner; search starts just above it
  logic [WW-1:0]    wd_q, wd_d;
  logic             terr_q, terr_d;
  logic [PW-1:0]    tid_q, tid_d;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic             handshake;
  logic             last_sel;

  // Rotating search: first requester above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found && req[(int'(ptr_q) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign handshake = tx_valid && tx_ready;
  assign last_sel  = |(byte_last & grant_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      wd_q    <= '0;
      terr_q  <= 1'b0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
      tid_q   <= tid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    terr_d  = 1'b0;
    tid_d   = tid_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BURST;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          gidx_d  = win_idx;
          wd_d    = '0;
        end
      end
      BURST: begin
        if (handshake) begin
          // A handshake always wins over the watchdog, even on the limit cycle.
          wd_d = '0;
          if (last_sel) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = gidx_q;
          end
        end else if (wd_q == WD_LIMIT) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx_q;
          terr_d  = 1'b1;
          tid_d   = gidx_q;
        end else begin
          // Only reached below the limit, so the counter can never wrap.
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: one-hot AND-OR mux, forced quiet while rst is asserted.
  always_comb begin
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_dc      = 1'b0;
    byte_ready = '0;
    if (state_q == BURST && !rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        tx_valid = tx_valid | (byte_valid[i] & grant_q[i]);
        tx_data  = tx_data  | (byte_data[8*i +: 8] & {8{grant_q[i]}});
        tx_dc    = tx_dc    | (byte_dc[i] & grant_q[i]);
      end
      byte_ready = grant_q & {N_REQ{tx_ready}};
    end
  end

  assign grant        = grant_q;
  assign burst_active = (state_q == BURST);
  assign timeout_err  = terr_q;
  assign timeout_id   = tid_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// tb_oled_spi_arbiter: table vectors, directed corner sequences and random traffic for oled_spi_arbiter.
// Ports: none; drives N_REQ=3, TIMEOUT=16 instance.
// Inputs change on the falling edge, outputs are compared 1ns later.
module tb_oled_spi_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic [2:0]  req, byte_valid, byte_dc, byte_last, byte_ready, grant;
  logic [23:0] byte_data;
  logic        tx_valid, tx_dc, tx_ready, burst_active, timeout_err;
  logic [7:0]  tx_data;
  logic [1:0]  timeout_id;

  oled_spi_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_dc(byte_dc), .byte_last(byte_last), .byte_ready(byte_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_dc(tx_dc), .tx_ready(tx_ready),
    .burst_active(burst_active), .grant(grant), .timeout_err(timeout_err),
    .timeout_id(timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the transmitter and how long it has gone without a byte.
  int   m_owner;   // -1 when nobody holds the transmitter
  int   m_ptr;
  int   m_stall;   // consecutive no-handshake cycles in the current burst
  bit   m_terr;
  int   m_tid;
  bit   model_on;
  logic [7:0] got[$];

  task automatic model_step();
    bit hs;
    int best, bestd, d;
    if (rst) begin
      m_owner = -1; m_ptr = N - 1; m_stall = 0; m_terr = 0; m_tid = 0;
      return;
    end
    m_terr = 0;
    if (m_owner < 0) begin
      // Winner is the requesting index at the smallest rotational distance past the pointer.
      best = -1; bestd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_ptr - 1 + 2 * N) % N;
        if (req[i] && d < bestd) begin best = i; bestd = d; end
      end
      if (best >= 0) begin m_owner = best; m_stall = 0; end
    end else begin
      hs = byte_valid[m_owner] && tx_ready;
      if (hs) begin
        m_stall = 0;
        if (byte_last[m_owner]) begin m_ptr = m_owner; m_owner = -1; end
      end else begin
        m_stall++;
        if (m_stall == TO) begin
          m_terr = 1; m_tid = m_owner; m_ptr = m_owner; m_owner = -1; m_stall = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    bit act;
    logic [2:0] eg;
    act = (m_owner >= 0) && !rst;
    eg  = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    chk("grant", grant, eg);
    chk("burst_active", burst_active, m_owner >= 0);
    chk("tx_valid", tx_valid, act ? byte_valid[m_owner] : 1'b0);
    chk("tx_data", tx_data, act ? byte_data[8*m_owner +: 8] : 8'h00);
    chk("tx_dc", tx_dc, act ? byte_dc[m_owner] : 1'b0);
    chk("byte_ready", byte_ready, (act && tx_ready) ? eg : 3'b000);
    chk("timeout_err", timeout_err, m_terr);
    chk("timeout_id", timeout_id, m_tid);
  endtask

  // One clock: compare, record handshake bytes, advance model, move to next falling edge.
  task automatic cyc();
    #1;
    if (model_on) check_model();
    if (tx_valid && tx_ready) got.push_back(tx_data);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_grant(output logic [2:0] g);
    for (int i = 0; i < 10; i++) begin
      if (grant != 3'b000) break;
      cyc();
    end
    g = grant;
    if (g == 3'b000) chk("wait_grant", g, 3'b111);
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req, bv, dc, last;
    logic [23:0] data;
    logic        txr;
    logic [2:0]  eg, ebr;
    logic        etv;
    logic [7:0]  etd;
    logic        etdc, eba;
  } vec_t;

  function automatic vec_t mk(logic r, logic [2:0] rq, logic [2:0] bv, logic [23:0] d,
                              logic [2:0] dc, logic [2:0] l, logic txr, logic [2:0] eg,
                              logic [2:0] ebr, logic etv, logic [7:0] etd, logic etdc,
                              logic eba);
    vec_t v;
    v.rst = r; v.req = rq; v.bv = bv; v.data = d; v.dc = dc; v.last = l; v.txr = txr;
    v.eg = eg; v.ebr = ebr; v.etv = etv; v.etd = etd; v.etdc = etdc; v.eba = eba;
    return v;
  endfunction

  vec_t tbl[7];

  initial begin
    logic [2:0] g;
    logic [2:0] gseq[4];
    logic [2:0] exp_seq[4];
    logic [7:0] b3[3];
    logic       rdy_pat[8];
    int         idx, cnt, mode;

    // Single requester burst AE A0 72 AF; other lanes carry noise that must be ignored.
    tbl[0] = mk(1, 3'b000, 3'b000, 24'h000000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 0, 8'h00, 0, 0);
    tbl[1] = mk(0, 3'b001, 3'b000, 24'h556600, 3'b110, 3'b000, 1, 3'b000, 3'b000, 0, 8'h00, 0, 0);
    tbl[2] = mk(0, 3'b001, 3'b111, 24'h5566AE, 3'b110, 3'b000, 1, 3'b001, 3'b001, 1, 8'hAE, 0, 1);
    tbl[3] = mk(0, 3'b001, 3'b111, 24'h5566A0, 3'b110, 3'b000, 1, 3'b001, 3'b001, 1, 8'hA0, 0, 1);
    tbl[4] = mk(0, 3'b001, 3'b111, 24'h556672, 3'b110, 3'b000, 1, 3'b001, 3'b001, 1, 8'h72, 0, 1);
    tbl[5] = mk(0, 3'b001, 3'b111, 24'h5566AF, 3'b110, 3'b001, 1, 3'b001, 3'b001, 1, 8'hAF, 0, 1);
    tbl[6] = mk(0, 3'b000, 3'b111, 24'h556677, 3'b111, 3'b000, 1, 3'b000, 3'b000, 0, 8'h00, 0, 0);

    rst = 1; req = 0; byte_valid = 0; byte_data = 0; byte_dc = 0; byte_last = 0; tx_ready = 1;
    m_owner = -1; m_ptr = N - 1; m_stall = 0; m_terr = 0; m_tid = 0; model_on = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; byte_valid = tbl[i].bv; byte_data = tbl[i].data;
      byte_dc = tbl[i].dc; byte_last = tbl[i].last; tx_ready = tbl[i].txr;
      #1;
      chk("tbl_grant", grant, tbl[i].eg);
      chk("tbl_byte_ready", byte_ready, tbl[i].ebr);
      chk("tbl_tx_valid", tx_valid, tbl[i].etv);
      chk("tbl_tx_data", tx_data, tbl[i].etd);
      chk("tbl_tx_dc", tx_dc, tbl[i].etdc);
      chk("tbl_burst_active", burst_active, tbl[i].eba);
      if (i == 0) chk("tbl_timeout_err", timeout_err, 1'b0);
      model_step();
      @(negedge clk);
    end
    model_on = 1;

    // Round robin with all requesters busy, 2-byte bursts, one idle cycle between.
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
    rst = 1; cyc(); rst = 0;
    req = 3'b111; byte_valid = 3'b111; tx_ready = 1; byte_data = 24'h332211;
    for (int b = 0; b < 4; b++) begin
      byte_last = 3'b000;
      wait_grant(g);
      gseq[b] = g;
      cyc();
      byte_last = 3'b111;
      cyc();
      chk("rr_idle_gap", grant, 3'b000);
      cyc();
    end
    for (int b = 0; b < 4; b++) chk("rr_seq", gseq[b], exp_seq[b]);

    // Backpressure on requester 2.
    req = 3'b100; byte_valid = 3'b000; byte_last = 3'b000;
    while (grant != 3'b000) cyc();
    b3[0] = 8'h11; b3[1] = 8'h22; b3[2] = 8'h33;
    rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0; rdy_pat[3] = 1;
    rdy_pat[4] = 1; rdy_pat[5] = 1; rdy_pat[6] = 1; rdy_pat[7] = 1;
    wait_grant(g);
    chk("bp_grant", g, 3'b100);
    got.delete();
    idx = 0;
    for (int c = 0; c < 8 && idx < 3; c++) begin
      byte_valid = 3'b100; byte_data = {b3[idx], 16'hBEEF};
      byte_last = (idx == 2) ? 3'b100 : 3'b000; tx_ready = rdy_pat[c];
      cyc();
      if (rdy_pat[c]) idx++;
    end
    chk("bp_count", got.size(), 3);
    for (int k = 0; k < 3 && k < got.size(); k++) chk("bp_byte", got[k], b3[k]);

    // Watchdog: requester 1 sends one byte then stalls while requester 2 waits.
    req = 3'b010; byte_valid = 3'b000; byte_last = 3'b000; tx_ready = 1;
    wait_grant(g);
    chk("wd_grant", g, 3'b010);
    byte_valid = 3'b010; byte_data = 24'h00C300;
    cyc();
    byte_valid = 3'b000; req = 3'b110;
    cnt = 0;
    while (!timeout_err && cnt < 40) begin cyc(); cnt++; end
    chk("wd_edges", cnt, TO);
    chk("wd_id", timeout_id, 2'd1);
    chk("wd_grant_drop", grant, 3'b000);
    cyc();
    chk("wd_next_owner", grant, 3'b100);
    chk("wd_pulse_width", timeout_err, 1'b0);

    // Handshake exactly on the limit cycle keeps the burst alive.
    req = 3'b000;
    repeat (TO - 1) cyc();
    byte_valid = 3'b100; byte_data = 24'h5A0000;
    cyc();
    byte_valid = 3'b000;
    chk("limit_no_timeout", timeout_err, 1'b0);
    chk("limit_grant_kept", grant, 3'b100);
    repeat (3) cyc();
    byte_valid = 3'b100; byte_last = 3'b100;
    cyc();
    byte_valid = 3'b000; byte_last = 3'b000;
    cyc();

    // Reset in the middle of a 6-byte burst from requester 0.
    req = 3'b001;
    wait_grant(g);
    chk("rst_grant", g, 3'b001);
    byte_valid = 3'b001;
    byte_data = 24'h000001; cyc();
    byte_data = 24'h000002; cyc();
    byte_data = 24'h000003; rst = 1;
    #1;
    chk("rst_no_ready", byte_ready, 3'b000);
    cyc();
    rst = 0; req = 3'b110;
    #1;
    chk("rst_grant_drop", grant, 3'b000);
    chk("rst_burst_drop", burst_active, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    cyc();
    chk("rst_first_winner", grant, 3'b010);
    byte_valid = 3'b010; byte_last = 3'b010; cyc();
    byte_valid = 3'b000; byte_last = 3'b000; req = 3'b000; cyc();

    // Random traffic against the model, with phases that provoke stalls and timeouts.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) mode = $urandom_range(0, 2);
      rst        = ($urandom_range(0, 499) == 0);
      req        = 3'($urandom);
      byte_valid = (mode == 2) ? 3'b000 : 3'($urandom);
      byte_data  = 24'($urandom);
      byte_dc    = 3'($urandom);
      for (int k = 0; k < 3; k++) byte_last[k] = ($urandom_range(0, 3) == 0);
      tx_ready   = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
